// File: rtl/feather_pkg.sv
// Shared types for the feather pipeline: register indices and the issue
// bundle handed from operand fetch to execute.
package feather_pkg;
  localparam int REG_ADDR_W = 4;
  localparam int NUM_REGS   = 16;
  localparam int DATA_W     = 32;
  localparam int OP_W       = 8;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    reg_addr_t         rd;
    logic              rd_we;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } issue_t;

  function automatic logic idx_hit(input logic en, input reg_addr_t x, input reg_addr_t y);
    return en && (x == y);
  endfunction
endpackage

// File: rtl/scoreboard.sv
// Busy vector of in-flight destination registers. Set beats clear; the
// pending lookup already discounts a same-cycle writeback.
module scoreboard
  import feather_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                set_en_i,
  input  reg_addr_t           set_idx_i,
  input  logic                wb_en_i,
  input  reg_addr_t           wb_idx_i,
  input  logic                fl_en_i,
  input  reg_addr_t           fl_idx_i,
  input  reg_addr_t           q0_idx_i,
  input  reg_addr_t           q1_idx_i,
  input  reg_addr_t           q2_idx_i,
  output logic                q0_pend_o,
  output logic                q1_pend_o,
  output logic                q2_pend_o,
  output logic [NUM_REGS-1:0] busy_o
);

  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_busy_next;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_bit
      always_comb begin
        w_busy_next[gi] = r_busy[gi];
        if (idx_hit(set_en_i, set_idx_i, reg_addr_t'(gi))) begin
          w_busy_next[gi] = 1'b1;
        end else if (idx_hit(wb_en_i, wb_idx_i, reg_addr_t'(gi)) ||
                     idx_hit(fl_en_i, fl_idx_i, reg_addr_t'(gi))) begin
          w_busy_next[gi] = 1'b0;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_next;
    end
  end

  assign q0_pend_o = r_busy[q0_idx_i] && !idx_hit(wb_en_i, wb_idx_i, q0_idx_i);
  assign q1_pend_o = r_busy[q1_idx_i] && !idx_hit(wb_en_i, wb_idx_i, q1_idx_i);
  assign q2_pend_o = r_busy[q2_idx_i] && !idx_hit(wb_en_i, wb_idx_i, q2_idx_i);
  assign busy_o    = r_busy;

endmodule

// File: rtl/operand_fetch.sv
// Issue stage: reads operands with writeback bypass, stalls on RAW/WAW
// hazards against the scoreboard and registers the bundle for execute.
module operand_fetch
  import feather_pkg::*;
#(
  parameter int N   = DATA_W,
  parameter int OPW = OP_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid_i,
  output logic           in_ready_o,
  input  logic [OPW-1:0] in_op_i,
  input  logic [3:0]     in_rs1_i,
  input  logic [3:0]     in_rs2_i,
  input  logic           in_rs1_use_i,
  input  logic           in_rs2_use_i,
  input  logic [3:0]     in_rd_i,
  input  logic           in_rd_we_i,
  output logic [3:0]     rf_addr1_o,
  output logic [3:0]     rf_addr2_o,
  input  logic [N-1:0]   rf_data1_i,
  input  logic [N-1:0]   rf_data2_i,
  input  logic           wb_valid_i,
  input  logic [3:0]     wb_rd_i,
  input  logic [N-1:0]   wb_data_i,
  input  logic           flush_i,
  output logic           out_valid_o,
  input  logic           out_ready_i,
  output logic [OPW-1:0] out_op_o,
  output logic [3:0]     out_rd_o,
  output logic           out_rd_we_o,
  output logic [N-1:0]   out_a_o,
  output logic [N-1:0]   out_b_o,
  output logic [15:0]    busy_o
);

  issue_t      r_out;
  logic        r_valid;
  logic [N-1:0] w_op_a;
  logic [N-1:0] w_op_b;
  logic        w_pend1;
  logic        w_pend2;
  logic        w_pend_rd;
  logic        w_hazard;
  logic        w_accept;
  logic        w_fl_clr;

  assign rf_addr1_o = in_rs1_i;
  assign rf_addr2_o = in_rs2_i;

  // reg_file commits at the edge, so a same-cycle writeback must be forwarded
  assign w_op_a = idx_hit(wb_valid_i, wb_rd_i, in_rs1_i) ? wb_data_i : rf_data1_i;
  assign w_op_b = idx_hit(wb_valid_i, wb_rd_i, in_rs2_i) ? wb_data_i : rf_data2_i;

  assign w_hazard   = (in_rs1_use_i && w_pend1) || (in_rs2_use_i && w_pend2) ||
                      (in_rd_we_i && w_pend_rd);
  assign in_ready_o = !flush_i && !w_hazard && (!r_valid || out_ready_i);
  assign w_accept   = in_valid_i && in_ready_o;
  assign w_fl_clr   = flush_i && r_valid && r_out.rd_we;

  scoreboard u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_en_i  (w_accept && in_rd_we_i),
    .set_idx_i (in_rd_i),
    .wb_en_i   (wb_valid_i),
    .wb_idx_i  (wb_rd_i),
    .fl_en_i   (w_fl_clr),
    .fl_idx_i  (r_out.rd),
    .q0_idx_i  (in_rs1_i),
    .q1_idx_i  (in_rs2_i),
    .q2_idx_i  (in_rd_i),
    .q0_pend_o (w_pend1),
    .q1_pend_o (w_pend2),
    .q2_pend_o (w_pend_rd),
    .busy_o    (busy_o)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_out   <= '0;
    end else if (flush_i) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid     <= 1'b1;
      r_out.op    <= in_op_i;
      r_out.rd    <= in_rd_i;
      r_out.rd_we <= in_rd_we_i;
      r_out.a     <= w_op_a;
      r_out.b     <= w_op_b;
    end else if (out_ready_i) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid_o = r_valid;
  assign out_op_o    = r_out.op;
  assign out_rd_o    = r_out.rd;
  assign out_rd_we_o = r_out.rd_we;
  assign out_a_o     = r_out.a;
  assign out_b_o     = r_out.b;

endmodule

// File: doc/operand_fetch.md
# operand_fetch

Issue/operand-read stage sitting directly upstream of `reg_file`, between decode and execute. Accepts one decoded instruction per cycle over a valid/ready handshake, drives the register file's two read addresses, and bypasses same-cycle writeback data. Tracks in-flight destination registers in a 16-entry scoreboard and stalls on RAW/WAW hazards. Presents a registered operand bundle to execute with one cycle of latency.

## Interface
- `N`, 32: data width; matches `reg_file`.
- `OPW`, 8: width of the opaque op tag passed through to execute.

- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  synchronous reset, active-low
- `in_valid_i`  in  1  decoded instruction present
- `in_ready_o`  out  1  stage accepts this cycle
- `in_op_i`  in  OPW  op tag
- `in_rs1_i`, `in_rs2_i`  in  4  source register indices
- `in_rs1_use_i`, `in_rs2_use_i`  in  1  source is actually read
- `in_rd_i`  in  4  destination index
- `in_rd_we_i`  in  1  instruction writes `rd`
- `rf_addr1_o`, `rf_addr2_o`  out  4  register file read addresses; equal to `in_rs1_i` and `in_rs2_i`
- `rf_data1_i`, `rf_data2_i`  in  N  register file read data (combinational)
- `wb_valid_i`  in  1  writeback this cycle; same signal drives `reg_file` write enable
- `wb_rd_i`  in  4  writeback register
- `wb_data_i`  in  N  writeback data
- `flush_i`  in  1  kill the instruction held in the output register
- `out_valid_o`  out  1  operand bundle valid
- `out_ready_i`  in  1  execute accepts
- `out_op_o`  out  OPW  op tag
- `out_rd_o`  out  4  destination index
- `out_rd_we_o`  out  1  destination write flag
- `out_a_o`, `out_b_o`  out  N  operands 1 and 2
- `busy_o`  out  16  scoreboard state, for debug

## Operation
- **Bypass:** `opX = (wb_valid_i && wb_rd_i == in_rsX_i) ? wb_data_i : rf_dataX_i`. This is needed because `reg_file` commits its write at the clock edge.
- **Pending test:** register r is pending when `busy[r] && !(wb_valid_i && wb_rd_i == r)`.
- **Hazard** is asserted when any of the following holds:
  - `in_rs1_use_i` and rs1 is pending;
  - `in_rs2_use_i` and rs2 is pending;
  - `in_rd_we_i` and rd is pending (WAW).
- **Ready:** `in_ready_o = !flush_i && !hazard && (!out_valid_o || out_ready_i)`.
  - `in_ready_o` may depend on the `in_*` payload.
  - It never depends on `in_valid_i`.
- **Accept** (`in_valid_i && in_ready_o`):
  - The output register loads op, rd, rd_we and the bypassed operands.
  - `out_valid_o` goes to 1 on the next cycle.
  - If `in_rd_we_i`, set `busy[in_rd_i]`.
- **Drain:** if `out_ready_i` and there is no accept, `out_valid_o` goes to 0.
- **Hold:** if `out_valid_o && !out_ready_i`, all `out_*` are held stable.
- **Writeback:** `wb_valid_i` clears `busy[wb_rd_i]`.
  - If the same register is set by an accept in the same cycle, set wins.
  - A writeback to a non-busy register is legal: no scoreboard change, and the bypass still applies.
- **Flush** (`flush_i`), applied on the next edge:
  - `out_valid_o` goes to 0.
  - If `out_valid_o && out_rd_we_o`, clear `busy[out_rd_o]`.
  - No accept occurs in a flush cycle.
  - Instructions already past this stage are not affected.
- r0–r15 are all treated identically; the scoreboard has no special registers.

## Timing
- Accept-to-`out_valid_o` latency is 1 cycle.
- Sustained throughput is 1 instruction/cycle when there is no hazard and `out_ready_i = 1`.
- A writeback in cycle t releases a dependent consumer in the same cycle t, through the bypass.
- Reset (`rst_n = 0` at an edge) forces:
  - `out_valid_o = 0`, `out_rd_we_o = 0`;
  - `out_op_o`, `out_rd_o`, `out_a_o`, `out_b_o` = 0;
  - `busy = 0`.
- Reset has priority over flush, writeback and accept. A reset mid-stall discards the held instruction.
- After reset, `in_ready_o = 1` with `flush_i = 0`.
- No combinational path from `out_ready_i` to `out_*`.

## Structure
- Shared package `feather_pkg`:
  - `REG_ADDR_W = 4`, `NUM_REGS = 16`;
  - typedef `reg_addr_t`;
  - a packed struct for the issue bundle (op, rd, rd_we, a, b).
- Sub-module `scoreboard` holds the 16-bit busy vector, with:
  - set port (index, enable) and clear ports (writeback index/enable, flush index/enable);
  - set-over-clear priority;
  - combinational pending lookup for three indices.

## Test plan
- **Back-to-back, no hazard:** issue `add r1←r2,r3` then `add r4←r5,r6`, with r2=5 and r3=7 in the register file, and `out_ready_i = 1` → bundles appear on consecutive cycles, the first with a=5, b=7; `busy_o = 0x0012`.
- **RAW stall:** issue r1←…, then r2←r1 while `busy[1]` is set → `in_ready_o = 0` until `wb_valid_i` with rd=1 and data 0x2A. The consumer is accepted in that same cycle with a=0x2A.
- **WAW stall:** issue with `busy[3]` set and `in_rd_i = 3`, `in_rd_we_i = 1` → stall.
  - Writeback r3 clears `busy[3]` and the new accept sets it again in the same edge.
  - Afterwards `busy_o[3] = 1`.
- **Backpressure:** `out_ready_i = 0` for 3 cycles with `out_valid_o = 1` → outputs held and `in_ready_o = 0`. After release, the next instruction is accepted with no loss or duplication.
- **Flush:** the held instruction writes r7 and `flush_i` is pulsed → `out_valid_o = 0` and `busy_o[7] = 0` next cycle; a simultaneous `in_valid_i` is not accepted.
- **Reset mid-stall:** `rst_n = 0` with busy=0x00FF and `out_valid_o = 1` → next cycle busy=0, all outputs 0, and `in_ready_o = 1`.
